// File: rtl/fg_output_sequencer_if.sv
// Configuration handshake and limiter-control bundle for fg_output_sequencer.
// master = configuration side, slave = sequencer.
interface fg_output_sequencer_if #(
    parameter int BITWIDTH   = 16,
    parameter int DATA_COUNT = 3
);
    localparam int SEL_W = $clog2(DATA_COUNT);

    logic                       sample_tick_i;
    logic                       cfg_valid_i;
    logic                       cfg_ready_o;
    logic                       cfg_enable_i;
    logic [SEL_W-1:0]           cfg_select_i;
    logic signed [BITWIDTH-1:0] cfg_offset_i;
    logic                       outputEnable_o;
    logic [SEL_W-1:0]           select_o;
    logic signed [BITWIDTH-1:0] offset_o;
    logic                       busy_o;

    modport master (
        output sample_tick_i, cfg_valid_i, cfg_enable_i, cfg_select_i, cfg_offset_i,
        input  cfg_ready_o, outputEnable_o, select_o, offset_o, busy_o
    );

    modport slave (
        input  sample_tick_i, cfg_valid_i, cfg_enable_i, cfg_select_i, cfg_offset_i,
        output cfg_ready_o, outputEnable_o, select_o, offset_o, busy_o
    );
endinterface

// File: rtl/fg_output_sequencer.sv
// Glitch-safe sequencer for the output limiter: mutes on source change, slews offset.
// Define FG_SEQ_OFFSET_RAMP_EN to enable offset slewing (RAMP state); otherwise offsets load directly.
module fg_output_sequencer #(
    parameter int BITWIDTH    = 16,
    parameter int DATA_COUNT  = 3,
    parameter int MUTE_CYCLES = 4,
    parameter int RAMP_STEP   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fg_output_sequencer_if.slave  bus
);
    localparam int SEL_W = $clog2(DATA_COUNT);
    localparam int CNT_W = $clog2(MUTE_CYCLES + 1);

    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] MUTE = 2'd2;
`ifdef FG_SEQ_OFFSET_RAMP_EN
    localparam logic [1:0] RAMP = 2'd3;
`endif

    if (DATA_COUNT < 2 || MUTE_CYCLES < 1 || RAMP_STEP < 1 ||
        RAMP_STEP >= (2 ** (BITWIDTH - 1))) begin : g_param_check
        $error("fg_output_sequencer: illegal parameter combination");
    end

    logic [1:0]                 state;
    logic                       out_enable;
    logic [SEL_W-1:0]           sel_q;
    logic signed [BITWIDTH-1:0] off_q;
    logic [SEL_W-1:0]           tgt_sel;
    logic signed [BITWIDTH-1:0] tgt_off;
    logic [CNT_W-1:0]           mute_cnt;
    logic                       ready;

    assign ready              = (state == OFF) || (state == RUN);
    assign bus.cfg_ready_o    = ready;
    assign bus.busy_o         = !ready;
    assign bus.outputEnable_o = out_enable;
    assign bus.select_o       = sel_q;
    assign bus.offset_o       = off_q;

`ifdef FG_SEQ_OFFSET_RAMP_EN
    // One extra bit so target - current never wraps at full-scale extremes.
    localparam logic signed [BITWIDTH:0] STEP_X = (BITWIDTH + 1)'(RAMP_STEP);

    logic signed [BITWIDTH:0] off_x;
    logic signed [BITWIDTH:0] diff;
    logic signed [BITWIDTH:0] step_up;
    logic signed [BITWIDTH:0] step_dn;

    always_comb begin
        off_x   = {off_q[BITWIDTH-1], off_q};
        diff    = {tgt_off[BITWIDTH-1], tgt_off} - off_x;
        step_up = off_x + STEP_X;
        step_dn = off_x - STEP_X;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= OFF;
            out_enable <= 1'b0;
            sel_q      <= '0;
            off_q      <= '0;
            tgt_sel    <= '0;
            tgt_off    <= '0;
            mute_cnt   <= '0;
        end else begin
            case (state)
                OFF, RUN: begin
                    if (bus.cfg_valid_i) begin
                        tgt_sel <= bus.cfg_select_i;
                        tgt_off <= bus.cfg_offset_i;
                        if (!bus.cfg_enable_i) begin
                            state      <= OFF;
                            out_enable <= 1'b0;
                            sel_q      <= bus.cfg_select_i;
                            off_q      <= bus.cfg_offset_i;
                        end else if (state == OFF) begin
                            state      <= RUN;
                            out_enable <= 1'b1;
                            sel_q      <= bus.cfg_select_i;
                            off_q      <= bus.cfg_offset_i;
                        end else if (bus.cfg_select_i != sel_q) begin
                            state      <= MUTE;
                            out_enable <= 1'b0;
                            mute_cnt   <= CNT_W'(MUTE_CYCLES);
                        end else if (bus.cfg_offset_i != off_q) begin
`ifdef FG_SEQ_OFFSET_RAMP_EN
                            state <= RAMP;
`else
                            off_q <= bus.cfg_offset_i;
`endif
                        end
                    end
                end
                MUTE: begin
                    if (bus.sample_tick_i) begin
                        if (mute_cnt == CNT_W'(1)) begin
                            mute_cnt   <= '0;
                            sel_q      <= tgt_sel;
                            out_enable <= 1'b1;
`ifdef FG_SEQ_OFFSET_RAMP_EN
                            state <= (off_q != tgt_off) ? RAMP : RUN;
`else
                            off_q <= tgt_off;
                            state <= RUN;
`endif
                        end else begin
                            mute_cnt <= mute_cnt - CNT_W'(1);
                        end
                    end
                end
`ifdef FG_SEQ_OFFSET_RAMP_EN
                RAMP: begin
                    if (bus.sample_tick_i) begin
                        if (diff > STEP_X) begin
                            off_q <= step_up[BITWIDTH-1:0];
                        end else if (diff < -STEP_X) begin
                            off_q <= step_dn[BITWIDTH-1:0];
                        end else begin
                            off_q <= tgt_off;
                            state <= RUN;
                        end
                    end
                end
`endif
                default: state <= OFF;
            endcase
        end
    end
endmodule

// File: tb/tb_fg_output_sequencer.sv
// Self-checking bench for fg_output_sequencer; expectations follow FG_SEQ_OFFSET_RAMP_EN.
module tb_fg_output_sequencer;
    localparam int BW = 16;
    localparam int DC = 3;
    localparam int MC = 4;
    localparam int RS = 64;

    typedef struct {
        logic              oe;
        logic [1:0]        sel;
        logic signed [15:0] off;
        logic              rdy;
    } exp_t;

    typedef struct {
        logic              en;
        logic [1:0]        sel;
        logic signed [15:0] off;
        logic              exp_oe;
        logic [1:0]        exp_sel;
        logic signed [15:0] exp_off;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    fg_output_sequencer_if #(.BITWIDTH(BW), .DATA_COUNT(DC)) bus ();

    fg_output_sequencer #(
        .BITWIDTH(BW), .DATA_COUNT(DC), .MUTE_CYCLES(MC), .RAMP_STEP(RS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    task automatic push_exp(input logic oe, input logic [1:0] sel,
                            input logic signed [15:0] off, input logic rdy);
        exp_t e;
        e.oe = oe; e.sel = sel; e.off = off; e.rdy = rdy;
        sb.push_back(e);
    endtask

    task automatic check(input string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (bus.outputEnable_o !== e.oe || bus.select_o !== e.sel ||
                bus.offset_o !== e.off || bus.cfg_ready_o !== e.rdy ||
                bus.busy_o !== !e.rdy) begin
                n_err++;
                $display("FAIL %s: got oe=%0b sel=%0d off=%0d rdy=%0b busy=%0b, want oe=%0b sel=%0d off=%0d rdy=%0b busy=%0b",
                         name, bus.outputEnable_o, bus.select_o, bus.offset_o,
                         bus.cfg_ready_o, bus.busy_o, e.oe, e.sel, e.off, e.rdy, !e.rdy);
            end
        end
    endtask

    // Present a request, wait (bounded) for ready, let it be accepted on the next edge.
    task automatic apply(input logic en, input logic [1:0] sel,
                         input logic signed [15:0] off, input logic tick_on_accept);
        int n;
        n = 0;
        bus.cfg_enable_i = en;
        bus.cfg_select_i = sel;
        bus.cfg_offset_i = off;
        bus.cfg_valid_i  = 1'b1;
        while (!bus.cfg_ready_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cfg_ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got ready=0 after %0d cycles, want ready=1", n);
        end
        bus.sample_tick_i = tick_on_accept;
        @(posedge clk); #1;
        bus.cfg_valid_i   = 1'b0;
        bus.sample_tick_i = 1'b0;
    endtask

    task automatic do_tick();
        bus.sample_tick_i = 1'b1;
        @(posedge clk); #1;
        bus.sample_tick_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        vecs[0] = '{1'b1, 2'd2, 16'sd100,    1'b1, 2'd2, 16'sd100};
        vecs[1] = '{1'b1, 2'd2, 16'sd100,    1'b1, 2'd2, 16'sd100};
        vecs[2] = '{1'b0, 2'd1, -16'sd5,     1'b0, 2'd1, -16'sd5};
        vecs[3] = '{1'b0, 2'd0, 16'sd32767,  1'b0, 2'd0, 16'sd32767};
        vecs[4] = '{1'b1, 2'd1, 16'sh8000,   1'b1, 2'd1, 16'sh8000};
        vecs[5] = '{1'b0, 2'd2, 16'sd0,      1'b0, 2'd2, 16'sd0};
        vecs[6] = '{1'b1, 2'd2, 16'sd100,    1'b1, 2'd2, 16'sd100};

        bus.sample_tick_i = 1'b0;
        bus.cfg_valid_i   = 1'b0;
        bus.cfg_enable_i  = 1'b0;
        bus.cfg_select_i  = '0;
        bus.cfg_offset_i  = '0;

        repeat (2) @(posedge clk);
        #1;
        push_exp(1'b0, 2'd0, 16'sd0, 1'b1);
        check("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].en, vecs[i].sel, vecs[i].off, 1'b0);
            push_exp(vecs[i].exp_oe, vecs[i].exp_sel, vecs[i].exp_off, 1'b1);
            check($sformatf("vec%0d", i));
        end

        // Source change: tick on the accept edge does not count; a held request stalls.
        apply(1'b1, 2'd1, 16'sd100, 1'b1);
        push_exp(1'b0, 2'd2, 16'sd100, 1'b0);
        check("mute_entry");
        bus.cfg_enable_i = 1'b0;
        bus.cfg_select_i = 2'd0;
        bus.cfg_offset_i = 16'sd7;
        bus.cfg_valid_i  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            idle(1);
            do_tick();
            push_exp(1'b0, 2'd2, 16'sd100, 1'b0);
            check($sformatf("mute_hold%0d", k));
        end
        do_tick();
        push_exp(1'b1, 2'd1, 16'sd100, 1'b1);
        check("mute_done");
        idle(1);
        bus.cfg_valid_i = 1'b0;
        push_exp(1'b0, 2'd0, 16'sd7, 1'b1);
        check("stalled_req_accept");

        apply(1'b1, 2'd0, 16'sd100, 1'b0);
        push_exp(1'b1, 2'd0, 16'sd100, 1'b1);
        check("run_s0_100");

        apply(1'b1, 2'd0, 16'sd300, 1'b0);
`ifdef FG_SEQ_OFFSET_RAMP_EN
        push_exp(1'b1, 2'd0, 16'sd100, 1'b0);
        check("ramp_entry");
        idle(2);
        push_exp(1'b1, 2'd0, 16'sd100, 1'b0);
        check("ramp_hold");
        do_tick(); push_exp(1'b1, 2'd0, 16'sd164, 1'b0); check("ramp_t1");
        do_tick(); push_exp(1'b1, 2'd0, 16'sd228, 1'b0); check("ramp_t2");
        do_tick(); push_exp(1'b1, 2'd0, 16'sd292, 1'b0); check("ramp_t3");
        do_tick(); push_exp(1'b1, 2'd0, 16'sd300, 1'b1); check("ramp_t4");
`else
        push_exp(1'b1, 2'd0, 16'sd300, 1'b1);
        check("offset_direct");
`endif

        // Source and offset change together: mute, then the offset follows.
        apply(1'b1, 2'd2, 16'sd50, 1'b0);
        push_exp(1'b0, 2'd0, 16'sd300, 1'b0);
        check("mute2_entry");
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            push_exp(1'b0, 2'd0, 16'sd300, 1'b0);
            check($sformatf("mute2_hold%0d", k));
        end
        do_tick();
`ifdef FG_SEQ_OFFSET_RAMP_EN
        push_exp(1'b1, 2'd2, 16'sd300, 1'b0); check("mute2_done");
        do_tick(); push_exp(1'b1, 2'd2, 16'sd236, 1'b0); check("ramp2_t1");
        do_tick(); push_exp(1'b1, 2'd2, 16'sd172, 1'b0); check("ramp2_t2");
        do_tick(); push_exp(1'b1, 2'd2, 16'sd108, 1'b0); check("ramp2_t3");
        do_tick(); push_exp(1'b1, 2'd2, 16'sd50,  1'b1); check("ramp2_t4");
`else
        push_exp(1'b1, 2'd2, 16'sd50, 1'b1);
        check("mute2_done");
`endif

        // Full-scale swing.
        apply(1'b0, 2'd0, 16'sd32767, 1'b0);
        push_exp(1'b0, 2'd0, 16'sd32767, 1'b1);
        check("xs_off");
        apply(1'b1, 2'd0, 16'sd32767, 1'b0);
        push_exp(1'b1, 2'd0, 16'sd32767, 1'b1);
        check("xs_run");
        apply(1'b1, 2'd0, 16'sh8000, 1'b0);
`ifdef FG_SEQ_OFFSET_RAMP_EN
        push_exp(1'b1, 2'd0, 16'sd32767, 1'b0);
        check("xramp_entry");
        for (int k = 1; k <= 1024; k++) begin
            do_tick();
            e = 32767 - RS * k;
            if (e < -32768) e = -32768;
            push_exp(1'b1, 2'd0, 16'(e), (k == 1024));
            check($sformatf("xramp_t%0d", k));
        end
`else
        push_exp(1'b1, 2'd0, 16'sh8000, 1'b1);
        check("xs_direct");
`endif

        // Asynchronous reset in the middle of a transition.
        apply(1'b1, 2'd0, 16'sd1000, 1'b0);
`ifdef FG_SEQ_OFFSET_RAMP_EN
        push_exp(1'b1, 2'd0, 16'sh8000, 1'b0);
        check("rramp_entry");
        do_tick();
        push_exp(1'b1, 2'd0, -16'sd32704, 1'b0);
        check("rramp_t1");
`else
        push_exp(1'b1, 2'd0, 16'sd1000, 1'b1);
        check("r_direct");
`endif
        #2 rst = 1'b1;
        #1;
        push_exp(1'b0, 2'd0, 16'sd0, 1'b1);
        check("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(1'b0, 2'd0, 16'sd0, 1'b1);
        check("reset_release");
        apply(1'b1, 2'd2, 16'sd50, 1'b0);
        push_exp(1'b1, 2'd2, 16'sd50, 1'b1);
        check("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fg_output_sequencer.md
# fg_output_sequencer

Controller that drives the select, offset and output-enable inputs of the function generator's output limiter stage. It accepts configuration changes over a valid/ready handshake and applies them glitch-safely: a waveform-source change mutes the output for a fixed number of sample ticks before switching, and offset changes are slewed toward the target in bounded steps. It sits between the configuration register interface and the output limiter/saturation stage.

## Interface
- BITWIDTH, 16, width of the signed output sample and offset
- DATA_COUNT, 3, number of selectable waveform sources (≥ 2)
- MUTE_CYCLES, 4, sample ticks of mute on a source change (≥ 1)
- RAMP_STEP, 64, maximum offset change per sample tick (≥ 1, < 2^(BITWIDTH-1))

Ports:
- clk_i  in  1  system clock, all state updates on rising edge
- rst_i  in  1  asynchronous reset, active-high
- sample_tick_i  in  1  one-cycle strobe marking each output sample period
- cfg_valid_i  in  1  configuration request valid
- cfg_ready_o  out  1  configuration accepted when valid && ready
- cfg_enable_i  in  1  requested output enable
- cfg_select_i  in  $clog2(DATA_COUNT)  requested source index
- cfg_offset_i  in  BITWIDTH signed  requested offset
- outputEnable_o  out  1  to limiter output enable
- select_o  out  $clog2(DATA_COUNT)  to limiter source select
- offset_o  out  BITWIDTH signed  to limiter offset
- busy_o  out  1  transition in progress (MUTE or RAMP)

## Operation
- States: OFF, RUN, MUTE, RAMP. Reset state OFF.
- Reset values: outputEnable_o=0, select_o=0, offset_o=0, busy_o=0, cfg_ready_o=1; target registers and mute counter cleared.
- cfg_ready_o = 1 in OFF and RUN, 0 in MUTE and RAMP; busy_o = !cfg_ready_o. Requests presented while not ready stall; inputs must be held until accepted.
- On accept, cfg_enable/select/offset are latched as targets.
- Accept with enable=0 (any state that accepts): next cycle OFF, outputEnable_o=0, select_o and offset_o loaded directly with targets.
- OFF, accept with enable=1: next cycle RUN, outputEnable_o=1, select_o and offset_o loaded directly (no mute, no ramp).
- RUN, enable=1, select ≠ select_o: next cycle MUTE, outputEnable_o=0, mute counter = MUTE_CYCLES.
- RUN, enable=1, select = select_o, offset ≠ offset_o: next cycle RAMP.
- RUN, identical request: accepted, no output change, stays RUN.
- MUTE: counter decrements per sample_tick_i; on the tick where it reaches 0: select_o ← target, outputEnable_o=1, go RAMP if offset_o ≠ target, else RUN.
- RAMP: per sample_tick_i, diff = target − offset_o computed in BITWIDTH+1 bits; if |diff| ≤ RAMP_STEP then offset_o ← target and go RUN, else offset_o ± RAMP_STEP toward target. No overflow or wrap at full-scale extremes.
- Cycles without sample_tick_i: MUTE/RAMP hold.

## Timing
- Outputs registered; change on the edge after acceptance (1-cycle latency) for OFF/RUN direct loads and mute entry.
- MUTE duration: exactly MUTE_CYCLES sample ticks counted after entry; tick coinciding with the accept edge is not counted.
- Ramp: ceil(|Δoffset| / RAMP_STEP) ticks; cfg_ready_o returns 1 the cycle after the final step.
- rst_i mid-MUTE/RAMP: outputs go to reset values immediately (asynchronously), pending targets discarded.

## Configuration
- FG_SEQ_OFFSET_RAMP_EN defined: RAMP state and slewing as above.
- Not defined: RAMP state absent; offset-only change in RUN loads offset_o on the next cycle and stays RUN; on MUTE expiry select_o and offset_o both load target and state goes RUN.

## Test plan
- Reset asserted -> outputEnable_o=0, select_o=0, offset_o=0, cfg_ready_o=1, busy_o=0.
- OFF, accept enable=1 sel=2 off=100 -> next cycle outputEnable_o=1, select_o=2, offset_o=100, ready=1.
- RUN sel=2 off=100, accept sel=1 off=100, MUTE_CYCLES=4 -> enable 0 next cycle, select_o stays 2 until 4th tick, then select_o=1, enable=1, RUN; a request held meanwhile is stalled.
- Ramp (macro on) 100 -> 300, RAMP_STEP=64 -> offset_o 164, 228, 292, 300 on successive ticks, busy throughout; macro off -> 300 next cycle.
- Ramp 32767 -> −32768 -> monotonic decreasing, no wrap, reaches −32768 on tick 1024.
- rst_i pulsed mid-ramp -> immediate reset values, new request accepted right after release.
